// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer control/fetch bundle: redirect controls, imem handshake and fetch outputs.
// master = pipeline/control side, slave = fetch_sequencer.
interface fetch_sequencer_if #(
    parameter int unsigned PC_W = 16
);
    logic            pc_sel;
    logic            pc_bj_rf;
    logic            pc_br_jmp;
    logic            pc_run;
    logic [PC_W-1:0] base_pc;
    logic [7:0]      imm8;
    logic [11:0]     imm12;
    logic [PC_W-1:0] rf_target;
    logic            exec_req;
    logic            imem_ready;
    logic [15:0]     imem_rdata;
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     instr_out;
    logic            instr_valid;
    logic [PC_W-1:0] link_addr;
    logic            exec_busy;

    modport master (
        output pc_sel, pc_bj_rf, pc_br_jmp, pc_run, base_pc, imm8, imm12, rf_target, exec_req,
               imem_ready, imem_rdata,
        input  imem_addr, instr_out, instr_valid, link_addr, exec_busy
    );

    modport slave (
        input  pc_sel, pc_bj_rf, pc_br_jmp, pc_run, base_pc, imm8, imm12, rf_target, exec_req,
               imem_ready, imem_rdata,
        output imem_addr, instr_out, instr_valid, link_addr, exec_busy
    );
endinterface

// File: rtl/fetch_sequencer.sv
// PC sequencer with branch/jump/register redirects and imem stall handling.
// Define FETCH_EXEC_EN to compile in the EXEC (fetch one remote instruction, then return) sequence.
module fetch_sequencer #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter int unsigned PC_W         = 16
) (
    input  logic                clk,
    input  logic                rst,
    fetch_sequencer_if.slave    bus_io
);

`ifdef FETCH_EXEC_EN
    typedef enum logic [1:0] {StRun, StStall, StExecTgt, StExecRet} state_e;
`else
    typedef enum logic [0:0] {StRun, StStall} state_e;
`endif

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     instr_q, instr_d;
    logic            valid_q, valid_d;
    logic            busy;

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] br_tgt;
    logic [PC_W-1:0] jmp_tgt;
    logic [PC_W-1:0] redir_tgt;

`ifdef FETCH_EXEC_EN
    logic            busy_q, busy_d;
    logic [PC_W-1:0] ret_q, ret_d;
    assign busy = busy_q;
`else
    logic unused_exec_req;
    assign unused_exec_req = bus_io.exec_req;
    assign busy = 1'b0;
`endif

    assign pc_inc    = pc_q + 1'b1;
    assign br_tgt    = bus_io.base_pc + {{(PC_W-8){bus_io.imm8[7]}}, bus_io.imm8};
    assign jmp_tgt   = {bus_io.base_pc[PC_W-1:12], bus_io.imm12};
    assign redir_tgt = bus_io.pc_bj_rf  ? bus_io.rf_target :
                       bus_io.pc_br_jmp ? jmp_tgt : br_tgt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            pc_q    <= RESET_VECTOR[PC_W-1:0];
            instr_q <= 16'h0000;
            valid_q <= 1'b0;
`ifdef FETCH_EXEC_EN
            busy_q  <= 1'b0;
            ret_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
`ifdef FETCH_EXEC_EN
            busy_q  <= busy_d;
            ret_q   <= ret_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
`ifdef FETCH_EXEC_EN
        busy_d  = busy_q;
        ret_d   = ret_q;
        if (bus_io.exec_req && !busy_q) begin
            ret_d   = pc_q;
            pc_d    = bus_io.rf_target;
            busy_d  = 1'b1;
            valid_d = 1'b0;
            state_d = StExecTgt;
        end else if (state_q == StExecRet) begin
            pc_d    = ret_q;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            state_d = StRun;
        end else if (state_q == StExecTgt) begin
            // PC stays on the target; the return state restores it.
            if (bus_io.pc_run && bus_io.imem_ready) begin
                instr_d = bus_io.imem_rdata;
                valid_d = 1'b1;
                state_d = StExecRet;
            end
        end else
`endif
        if (bus_io.pc_sel && !busy) begin
            pc_d    = redir_tgt;
            valid_d = 1'b0;
            state_d = StRun;
        end else if (!bus_io.pc_run) begin
            // hold everything
        end else if (!bus_io.imem_ready) begin
            valid_d = 1'b0;
            state_d = StStall;
        end else begin
            instr_d = bus_io.imem_rdata;
            valid_d = 1'b1;
            pc_d    = pc_inc;
            state_d = StRun;
        end
    end

    always_comb begin
        bus_io.imem_addr   = pc_q;
        bus_io.instr_out   = instr_q;
        bus_io.instr_valid = valid_q;
        bus_io.link_addr   = bus_io.base_pc;
        bus_io.exec_busy   = busy;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; imem returns ~address so fetched words are predictable.
module tb_fetch_sequencer;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_fail;

    fetch_sequencer_if #(.PC_W(16)) bus ();

    fetch_sequencer #(.RESET_VECTOR(16'h0000), .PC_W(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus.slave)
    );

    assign bus.imem_rdata = ~bus.imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_vec++; if (bus.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr got %h want %h", bus.imem_addr, 16'h0000); end
        n_vec++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.instr_valid); end
        n_vec++; if (bus.instr_out !== 16'h0000) begin n_fail++; $display("FAIL reset_instr got %h want 0000", bus.instr_out); end
        n_vec++; if (bus.exec_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.exec_busy); end
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            step();
            n_vec++; if (bus.imem_addr !== 16'(i)) begin n_fail++; $display("FAIL seq_addr%0d got %h want %h", i, bus.imem_addr, 16'(i)); end
            n_vec++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid%0d got %b want 1", i, bus.instr_valid); end
            n_vec++; if (bus.instr_out !== ~16'(i - 1)) begin n_fail++; $display("FAIL seq_instr%0d got %h want %h", i, bus.instr_out, ~16'(i - 1)); end
        end
    endtask

    task automatic test_branch();
        // pc_run low: redirect must still win
        bus.pc_sel = 1'b1; bus.pc_bj_rf = 1'b0; bus.pc_br_jmp = 1'b0;
        bus.base_pc = 16'h0010; bus.imm8 = 8'hFC; bus.pc_run = 1'b0;
        step();
        bus.pc_sel = 1'b0; bus.pc_run = 1'b1;
        n_vec++; if (bus.imem_addr !== 16'h000C) begin n_fail++; $display("FAIL br_addr got %h want 000c", bus.imem_addr); end
        n_vec++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL br_bubble got %b want 0", bus.instr_valid); end
        step();
        n_vec++; if (bus.imem_addr !== 16'h000D) begin n_fail++; $display("FAIL br_next got %h want 000d", bus.imem_addr); end
        n_vec++; if (bus.instr_out !== 16'hFFF3) begin n_fail++; $display("FAIL br_instr got %h want fff3", bus.instr_out); end
    endtask

    task automatic test_jump_and_hold();
        bus.pc_sel = 1'b1; bus.pc_br_jmp = 1'b1; bus.base_pc = 16'h3005; bus.imm12 = 12'h0A0;
        #1;
        n_vec++; if (bus.link_addr !== 16'h3005) begin n_fail++; $display("FAIL link got %h want 3005", bus.link_addr); end
        step();
        bus.pc_sel = 1'b0;
        n_vec++; if (bus.imem_addr !== 16'h30A0) begin n_fail++; $display("FAIL jmp_addr got %h want 30a0", bus.imem_addr); end
        n_vec++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL jmp_bubble got %b want 0", bus.instr_valid); end
        step();
        bus.pc_run = 1'b0;
        step();
        step();
        n_vec++; if (bus.imem_addr !== 16'h30A1) begin n_fail++; $display("FAIL hold_addr got %h want 30a1", bus.imem_addr); end
        n_vec++; if (bus.instr_out !== 16'hCF5F) begin n_fail++; $display("FAIL hold_instr got %h want cf5f", bus.instr_out); end
        n_vec++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid got %b want 1", bus.instr_valid); end
        bus.pc_run = 1'b1;
    endtask

    task automatic test_wrap_stall();
        bus.pc_sel = 1'b1; bus.pc_bj_rf = 1'b1; bus.rf_target = 16'hFFFF;
        step();
        bus.pc_sel = 1'b0; bus.pc_bj_rf = 1'b0;
        n_vec++; if (bus.imem_addr !== 16'hFFFF) begin n_fail++; $display("FAIL rf_addr got %h want ffff", bus.imem_addr); end
        step();
        n_vec++; if (bus.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_addr got %h want 0000", bus.imem_addr); end
        n_vec++; if (bus.instr_out !== 16'h0000) begin n_fail++; $display("FAIL wrap_instr got %h want 0000", bus.instr_out); end
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++; if (bus.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL stall_addr%0d got %h want 0000", i, bus.imem_addr); end
            n_vec++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid%0d got %b want 0", i, bus.instr_valid); end
        end
        bus.imem_ready = 1'b1;
        step();
        n_vec++; if (bus.imem_addr !== 16'h0001) begin n_fail++; $display("FAIL unstall_addr got %h want 0001", bus.imem_addr); end
        n_vec++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL unstall_valid got %b want 1", bus.instr_valid); end
        n_vec++; if (bus.instr_out !== 16'hFFFF) begin n_fail++; $display("FAIL unstall_instr got %h want ffff", bus.instr_out); end
    endtask

`ifdef FETCH_EXEC_EN
    task automatic test_exec();
        bus.pc_sel = 1'b1; bus.pc_bj_rf = 1'b1; bus.rf_target = 16'h0020;
        step();
        bus.pc_sel = 1'b0;
        bus.exec_req = 1'b1; bus.rf_target = 16'h0100;
        step();
        bus.exec_req = 1'b0;
        n_vec++; if (bus.imem_addr !== 16'h0100) begin n_fail++; $display("FAIL exec_addr got %h want 0100", bus.imem_addr); end
        n_vec++; if (bus.exec_busy !== 1'b1) begin n_fail++; $display("FAIL exec_busy1 got %b want 1", bus.exec_busy); end
        // redirect and a second exec while busy must be ignored
        bus.imem_ready = 1'b0; bus.pc_sel = 1'b1; bus.rf_target = 16'h0555;
        step();
        n_vec++; if (bus.imem_addr !== 16'h0100) begin n_fail++; $display("FAIL exec_wait got %h want 0100", bus.imem_addr); end
        n_vec++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL exec_wait_valid got %b want 0", bus.instr_valid); end
        bus.imem_ready = 1'b1;
        step();
        bus.exec_req = 1'b1;
        n_vec++; if (bus.instr_out !== 16'hFEFF) begin n_fail++; $display("FAIL exec_instr got %h want feff", bus.instr_out); end
        n_vec++; if (bus.exec_busy !== 1'b1) begin n_fail++; $display("FAIL exec_busy2 got %b want 1", bus.exec_busy); end
        step();
        bus.exec_req = 1'b0; bus.pc_sel = 1'b0; bus.pc_bj_rf = 1'b0;
        n_vec++; if (bus.imem_addr !== 16'h0020) begin n_fail++; $display("FAIL exec_ret got %h want 0020", bus.imem_addr); end
        n_vec++; if (bus.exec_busy !== 1'b0) begin n_fail++; $display("FAIL exec_done got %b want 0", bus.exec_busy); end
        step();
        n_vec++; if (bus.imem_addr !== 16'h0021) begin n_fail++; $display("FAIL exec_resume got %h want 0021", bus.imem_addr); end
    endtask

    task automatic test_exec_reset();
        bus.exec_req = 1'b1; bus.rf_target = 16'h0200;
        step();
        bus.exec_req = 1'b0; bus.imem_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; bus.imem_ready = 1'b1;
        n_vec++; if (bus.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL xrst_addr got %h want 0000", bus.imem_addr); end
        n_vec++; if (bus.exec_busy !== 1'b0) begin n_fail++; $display("FAIL xrst_busy got %b want 0", bus.exec_busy); end
        n_vec++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL xrst_valid got %b want 0", bus.instr_valid); end
    endtask
`else
    task automatic test_exec_ignored();
        bus.exec_req = 1'b1; bus.rf_target = 16'h0200;
        step();
        bus.exec_req = 1'b0;
        n_vec++; if (bus.imem_addr !== 16'h0002) begin n_fail++; $display("FAIL noexec_addr got %h want 0002", bus.imem_addr); end
        n_vec++; if (bus.exec_busy !== 1'b0) begin n_fail++; $display("FAIL noexec_busy got %b want 0", bus.exec_busy); end
    endtask
`endif

    initial begin
        n_vec = 0; n_fail = 0;
        rst = 1'b1;
        bus.pc_sel = 1'b0; bus.pc_bj_rf = 1'b0; bus.pc_br_jmp = 1'b0; bus.pc_run = 1'b1;
        bus.base_pc = '0; bus.imm8 = '0; bus.imm12 = '0; bus.rf_target = '0;
        bus.exec_req = 1'b0; bus.imem_ready = 1'b1;
        test_reset();
        test_sequential();
        test_branch();
        test_jump_and_hold();
        test_wrap_stall();
`ifdef FETCH_EXEC_EN
        test_exec();
        test_exec_reset();
`else
        test_exec_ignored();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
